uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encodings, bit timing
// defaults and counter sizing.
package uart_rx_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
   localparam int unsigned CNT_W                = 12;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      START     = 5'b00010,
      DATA      = 5'b00100,
      STOP      = 5'b01000,
      WAIT_HIGH = 5'b10000
   } rx_state_t;

   // Terminal count for the start-bit phase: lands the first sample mid-bit.
   function automatic cnt_t half_bit_last(input int unsigned clks);
      return cnt_t'((clks - 1) / 2);
   endfunction

   function automatic cnt_t full_bit_last(input int unsigned clks);
      return cnt_t'(clks - 1);
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is
// selectable so idle-high lines come out of reset inactive.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, 8 data bits LSB
// first, stop-bit check with framing error and break (held-low) lockout.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       rx,
   output logic       received,
   output logic [7:0] receive_byte,
   output logic       framing_error,
   output logic       busy
);

   localparam cnt_t HALF_LAST = half_bit_last(CLKS_PER_BIT);
   localparam cnt_t BIT_LAST  = full_bit_last(CLKS_PER_BIT);

   logic       rx_s;
   rx_state_t  state, state_n;
   cnt_t       cnt, cnt_n;
   logic [2:0] bit_index, bit_index_n;
   logic [7:0] shift_reg, shift_reg_n;
   logic [7:0] receive_byte_n;
   logic       received_n;
   logic       framing_error_n;

   sync_2ff #(
      .RESET_VALUE(1'b1)
   ) u_sync (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .d       (rx),
      .q       (rx_s)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_index     <= '0;
         shift_reg     <= '0;
         receive_byte  <= '0;
         received      <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_index     <= bit_index_n;
         shift_reg     <= shift_reg_n;
         receive_byte  <= receive_byte_n;
         received      <= received_n;
         framing_error <= framing_error_n;
      end
   end

   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      bit_index_n     = bit_index;
      shift_reg_n     = shift_reg;
      receive_byte_n  = receive_byte;
      received_n      = 1'b0;
      framing_error_n = 1'b0;

      case (state)
         IDLE: begin
            cnt_n       = '0;
            bit_index_n = '0;
            if (!rx_s) state_n = START;
         end

         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n                  = '0;
               shift_reg_n[bit_index] = rx_s;
               if (bit_index == 3'd7) begin
                  bit_index_n = '0;
                  state_n     = STOP;
               end else begin
                  bit_index_n = bit_index + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  receive_byte_n = shift_reg;
                  received_n     = 1'b1;
                  state_n        = IDLE;
               end else begin
                  framing_error_n = 1'b1;
                  state_n         = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         // A break keeps the line low; only a return to idle re-arms start detection.
         WAIT_HIGH: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end

         default: begin
            state_n     = IDLE;
            cnt_n       = '0;
            bit_index_n = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed frame stimulus for uart_rx, scored against a
// frame-level model of expected bytes and pulse counts.
module tb_uart_rx;

   localparam int unsigned CPB = 16;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       rx;
   logic       received;
   logic [7:0] receive_byte;
   logic       framing_error;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_bad    = 0;
   int unsigned got_rx   = 0;
   int unsigned got_ferr = 0;
   int unsigned exp_rx   = 0;
   int unsigned exp_ferr = 0;
   logic [7:0] model_last = 8'h00;

   uart_rx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .rx           (rx),
      .received     (received),
      .receive_byte (receive_byte),
      .framing_error(framing_error),
      .busy         (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pulse counting on the falling edge; a stretched pulse counts twice.
   always @(negedge CLOCK_50) begin
      if (received) got_rx++;
      if (framing_error) begin
         got_ferr++;
         chk("keep_byte", {24'b0, receive_byte}, {24'b0, model_last});
      end
      if (received || framing_error)
         chk("excl", {31'b0, received & framing_error}, 32'd0);
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      rx = 1'b1;
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_nrx"}, got_rx, exp_rx);
      chk({tag, "_nfe"}, got_ferr, exp_ferr);
      chk({tag, "_byte"}, {24'b0, receive_byte}, {24'b0, model_last});
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      if (stop) begin
         exp_rx++;
         model_last = b;
      end else begin
         exp_ferr++;
      end
      for (int unsigned c = 0; c < 10 * CPB; c++) begin
         tick();
         rx = bits[c / CPB];
         if (c == 5 * CPB) chk("busy_mid", {31'b0, busy}, 32'd1);
         if (stop && c == 10 * CPB - 2) chk("busy_gap", {31'b0, busy}, 32'd0);
      end
      check_counts("frame");
   endtask

   task automatic hold_low(input int unsigned n);
      int unsigned rx_before;
      rx_before = got_rx;
      rx = 1'b0;
      for (int unsigned i = 0; i < n; i++) tick();
      chk("brk_busy", {31'b0, busy}, 32'd1);
      chk("brk_norx", got_rx, rx_before);
      rx = 1'b1;
      repeat (6) tick();
      chk("brk_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] b;
      logic       stop;

      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_byte", {24'b0, receive_byte}, 32'd0);
      chk("rst_rx",   {31'b0, received}, 32'd0);
      chk("rst_fe",   {31'b0, framing_error}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      idle(20);

      send_frame(8'h4A, 1'b1);
      idle(10);

      send_frame(8'h40, 1'b1);
      send_frame(8'h80, 1'b1);
      idle(10);
      check_counts("b2b");

      send_frame(8'hC3, 1'b0);
      hold_low(40);
      idle(20);
      check_counts("ferr");

      rx = 1'b0;
      repeat (5) tick();
      idle(30);
      chk("glitch_busy", {31'b0, busy}, 32'd0);
      check_counts("glitch");

      // Abort 0x55 during data bit 4 (frame bit 5) with a one-cycle reset.
      b = 8'h55;
      for (int unsigned c = 0; c <= 5 * CPB + CPB / 2; c++) begin
         tick();
         rx = (c < CPB) ? 1'b0 : b[(c / CPB) - 1];
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rx    = 1'b1;
      model_last = 8'h00;
      chk("mid_rst_byte", {24'b0, receive_byte}, 32'd0);
      chk("mid_rst_rx",   {31'b0, received}, 32'd0);
      chk("mid_rst_fe",   {31'b0, framing_error}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      idle(12 * CPB);
      check_counts("abort");
      send_frame(8'h81, 1'b1);
      idle(10);

      for (int unsigned k = 0; k < 24; k++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop);
         if (!stop) begin
            hold_low($urandom_range(20, 60));
            idle(CPB + $urandom_range(0, 20));
         end else begin
            idle($urandom_range(0, 30));
         end
      end
      idle(40);
      check_counts("final");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
